// File: rtl/rc4_xor_stage.sv
// RC4 keystream XOR stage: buffers keystream bytes in a FIFO and XORs them, in order, onto the data stream.
// Optional RC4_XOR_BYTECOUNT_EN adds a 16-bit transfer counter output byte_count.
module rc4_xor_stage #(
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ks_valid,
   input  logic [7:0]       ks_data,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   input  logic             out_ready,
   input  logic             clear,
   output logic [LVL_W-1:0] ks_level,
   output logic             ks_overflow
`ifdef RC4_XOR_BYTECOUNT_EN
   ,
   output logic [15:0]      byte_count
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {SYNC, RUN, FAULT} state_t;

   state_t           state_q, state_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             full, pop, push, drop;

   assign full     = (level_q == LVL_W'(FIFO_DEPTH));
   // Level is registered, so a byte pushed this cycle cannot be popped until the next one.
   assign in_ready = (state_q == RUN) && (level_q != '0) && (!out_valid_q || out_ready);
   assign pop      = in_valid && in_ready;
   assign push     = ks_valid && (state_q != FAULT) && (!full || pop);
   assign drop     = ks_valid && (state_q != FAULT) && full && !pop;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (clear) begin
         state_d     = SYNC;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
         out_data_d  = 8'h00;
      end else begin
         if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            out_data_d  = in_data ^ mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
         if (state_q == SYNC && ks_valid) begin
            state_d = RUN;
         end
         if (drop) begin
            ovf_d   = 1'b1;
            state_d = FAULT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SYNC;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst && !clear) begin
         mem_q[wr_ptr_q] <= ks_data;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign ks_level    = level_q;
   assign ks_overflow = ovf_q;

`ifdef RC4_XOR_BYTECOUNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (pop) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign byte_count = cnt_q;
`endif

endmodule

// File: tb/tb_rc4_xor_stage.sv
// Bench for rc4_xor_stage: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rc4_xor_stage;

   localparam int DEPTH = 16;
   localparam int LW    = 5;

   logic          clk = 1'b0;
   logic          rst, clear, ks_valid, in_valid, out_ready;
   logic [7:0]    ks_data, in_data;
   logic          in_ready, out_valid, ks_overflow;
   logic [7:0]    out_data;
   logic [LW-1:0] ks_level;
`ifdef RC4_XOR_BYTECOUNT_EN
   logic [15:0]   byte_count;
`endif

   rc4_xor_stage #(.FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
      .clk(clk), .rst(rst), .ks_valid(ks_valid), .ks_data(ks_data),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .clear(clear), .ks_level(ks_level), .ks_overflow(ks_overflow)
`ifdef RC4_XOR_BYTECOUNT_EN
      , .byte_count(byte_count)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: 0 = SYNC, 1 = RUN, 2 = FAULT
   int         m_state;
   bit [7:0]   ksq[$];
   bit         m_ovf, m_ovld;
   bit [7:0]   m_odata;
   int         m_cnt;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit m_ready(input bit ordy);
      return (m_state == 1) && (ksq.size() > 0) && (!m_ovld || ordy);
   endfunction

   task automatic m_reset();
      ksq.delete();
      m_state = 0;
      m_ovf   = 0;
      m_ovld  = 0;
      m_odata = 8'h00;
      m_cnt   = 0;
   endtask

   task automatic m_next(input bit r, input bit c, input bit kv, input bit [7:0] kd,
                         input bit iv, input bit [7:0] id, input bit ordy);
      bit rdy;
      bit [7:0] k;
      rdy = m_ready(ordy);
      if (r || c) begin
         m_reset();
         return;
      end
      if (iv && rdy) begin
         k       = ksq.pop_front();
         m_odata = id ^ k;
         m_ovld  = 1;
         m_cnt   = (m_cnt + 1) % 65536;
      end else if (ordy) begin
         m_ovld = 0;
      end
      if (kv && m_state != 2) begin
         if (m_state == 0) m_state = 1;
         if (ksq.size() < DEPTH) begin
            ksq.push_back(kd);
         end else begin
            m_ovf   = 1;
            m_state = 2;
         end
      end
   endtask

   // Drive one cycle of inputs, compare outputs of the current state, advance the model.
   task automatic step(input bit r, input bit c, input bit kv, input bit [7:0] kd,
                       input bit iv, input bit [7:0] id, input bit ordy);
      @(negedge clk);
      rst = r; clear = c; ks_valid = kv; ks_data = kd;
      in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      chk("out_valid",   16'(out_valid),   16'(m_ovld));
      chk("out_data",    16'(out_data),    16'(m_odata));
      chk("ks_level",    16'(ks_level),    16'(ksq.size()));
      chk("ks_overflow", 16'(ks_overflow), 16'(m_ovf));
      chk("in_ready",    16'(in_ready),    16'(m_ready(ordy)));
`ifdef RC4_XOR_BYTECOUNT_EN
      chk("byte_count",  byte_count,       16'(m_cnt));
`endif
      m_next(r, c, kv, kd, iv, id, ordy);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int kvrate;
      rst = 1'b1; clear = 1'b0; ks_valid = 1'b0; ks_data = 8'h00;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      m_reset();

      // Reset state and first transfer
      step(1, 0, 0, 8'h00, 0, 8'h00, 0);
      settle();
      chk("rst_in_ready", 16'(in_ready), 16'd0);
      chk("rst_out_data", 16'(out_data), 16'h00);
      chk("rst_level",    16'(ks_level), 16'd0);
      step(0, 0, 1, 8'hA5, 0, 8'h00, 1);
      step(0, 0, 0, 8'h00, 1, 8'h3C, 1);
      settle();
      chk("first_valid", 16'(out_valid), 16'd1);
      chk("first_data",  16'(out_data),  16'h99);
      chk("first_level", 16'(ks_level),  16'd0);

      // Fill, then overflow into FAULT
      step(1, 0, 0, 8'h00, 0, 8'h00, 1);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(i), 0, 8'h00, 1);
      step(0, 0, 1, 8'hEE, 0, 8'h00, 1);
      settle();
      chk("ovf_flag",     16'(ks_overflow), 16'd1);
      chk("ovf_level",    16'(ks_level),    16'd16);
      chk("ovf_in_ready", 16'(in_ready),    16'd0);
      step(0, 0, 1, 8'h55, 1, 8'h12, 1);
      settle();
      chk("fault_frozen", 16'(ks_level), 16'd16);

      // Leave FAULT via clear
      step(0, 1, 0, 8'h00, 0, 8'h00, 1);
      settle();
      chk("clr_level", 16'(ks_level),    16'd0);
      chk("clr_ovf",   16'(ks_overflow), 16'd0);
      chk("clr_valid", 16'(out_valid),   16'd0);

      // Leave FAULT via rst (with clear also asserted)
      for (int i = 0; i <= DEPTH; i++) step(0, 0, 1, 8'(i), 0, 8'h00, 1);
      step(1, 1, 1, 8'h00, 1, 8'h00, 1);
      settle();
      chk("rst_f_level", 16'(ks_level),    16'd0);
      chk("rst_f_ovf",   16'(ks_overflow), 16'd0);

      // Full FIFO with simultaneous push and pop, then backpressure
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(8'h10 + i), 0, 8'h00, 1);
      step(0, 0, 1, 8'h77, 1, 8'hAB, 1);
      settle();
      chk("full_pp_level", 16'(ks_level),    16'd16);
      chk("full_pp_ovf",   16'(ks_overflow), 16'd0);
      chk("full_pp_data",  16'(out_data),    16'hBB);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 8'h00, 1, 8'h55, 0);
         chk("hold_in_ready", 16'(in_ready), 16'd0);
         settle();
         chk("hold_data",  16'(out_data), 16'hBB);
         chk("hold_level", 16'(ks_level), 16'd16);
      end
      step(0, 0, 0, 8'h00, 1, 8'h55, 1);
      settle();
      chk("release_data", 16'(out_data), 16'h44);

      // 40-byte stream across pointer wrap
      step(1, 0, 0, 8'h00, 0, 8'h00, 1);
      for (int i = 0; i < 60; i++)
         step(0, 0, (i < 40), 8'($urandom), 1, 8'($urandom), 1);
      settle();
      chk("stream_level", 16'(ks_level), 16'd0);
`ifdef RC4_XOR_BYTECOUNT_EN
      chk("stream_count", byte_count, 16'd40);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         kvrate = 20 + 20 * ((i / 400) % 4);
         step(($urandom_range(0, 999) == 0), ($urandom_range(0, 149) == 0),
              ($urandom_range(0, 99) < kvrate), 8'($urandom),
              ($urandom_range(0, 99) < 70), 8'($urandom),
              ($urandom_range(0, 99) < 60));
      end
      step(0, 0, 0, 8'h00, 0, 8'h00, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rc4_xor_stage.md
RC4_XOR_STAGE -- requirements
Module: rc4_xor_stage

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, keystream FIFO depth in bytes (power of two, 4..64).
REQ-002 Parameter LVL_W, default 5, width of level output; SHALL equal log2(FIFO_DEPTH)+1.
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ks_valid  input  1  keystream byte present this cycle; driven by the upstream RC4 output_ready; no backpressure.
REQ-006 ks_data  input  8  keystream byte K.
REQ-007 in_valid  input  1  plaintext/ciphertext byte offered.
REQ-008 in_data  input  8  input byte.
REQ-009 in_ready  output  1  stage accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_data  output  8  in_data XOR keystream byte.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 clear  input  1  synchronous flush: empties FIFO, clears fault, returns to SYNC.
REQ-014 ks_level  output  LVL_W  current FIFO occupancy.
REQ-015 ks_overflow  output  1  sticky: keystream byte dropped, cipher alignment lost.

Function
REQ-016 States SYNC, RUN, FAULT; SYNC->RUN on first ks_valid; RUN->FAULT on overflow; any state->SYNC on clear.
REQ-017 Push: every cycle with ks_valid=1 and (level<FIFO_DEPTH or a pop occurs same cycle) SHALL write ks_data; writes allowed in SYNC and RUN, ignored in FAULT.
REQ-018 Overflow: ks_valid=1, level=FIFO_DEPTH, no pop same cycle -> byte dropped, ks_overflow<=1, state<=FAULT.
REQ-019 in_ready SHALL be 1 only when state=RUN, level>0 and (out_valid=0 or out_ready=1); combinational from registered state.
REQ-020 No bypass: a byte pushed in cycle N is poppable no earlier than cycle N+1.
REQ-021 Transfer (in_valid & in_ready) SHALL pop the FIFO head and register out_data<=in_data^head, out_valid<=1, next cycle (latency 1).
REQ-022 Keystream bytes SHALL be consumed strictly in arrival order, one per transfer; none skipped or reused.
REQ-023 out_valid=1 & out_ready=0 -> out_data, out_valid held stable; out_ready=1 without new transfer -> out_valid<=0.
REQ-024 Simultaneous push and pop SHALL leave level unchanged, including at level=0 is impossible (REQ-020) and at level=FIFO_DEPTH (no overflow).
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 In FAULT: in_ready=0; pending out_valid byte still drains; FIFO contents frozen.
REQ-027 clear has priority over push, pop and overflow in the same cycle; out register also cleared.

Reset
REQ-028 rst SHALL have priority over clear and all other inputs.
REQ-029 After rst: state=SYNC, level=0, pointers=0, in_ready=0, out_valid=0, out_data=8'h00, ks_overflow=0.
REQ-030 rst mid-transfer SHALL discard FIFO contents and any unaccepted out_data.

Configuration
REQ-031 Macro RC4_XOR_BYTECOUNT_EN defined: add output byte_count (16 bits), reset/clear to 0, +1 per transfer, wraps 16'hFFFF->0.
REQ-032 Macro undefined: port byte_count absent; all other behaviour identical.

Verification
REQ-033 Reset then ks_valid with ks_data=8'hA5, next cycle in_valid in_data=8'h3C -> one cycle later out_valid=1, out_data=8'h99, ks_level=0.
REQ-034 Push 16 bytes 0x00..0x0F, then 17th ks_valid with no input -> ks_overflow=1, state FAULT, in_ready=0, ks_level=16.
REQ-035 FIFO full, ks_valid and transfer same cycle -> ks_level stays 16, ks_overflow=0, out_data=in_data^first pushed byte.
REQ-036 out_ready held 0 for 3 cycles with out_valid=1 -> out_data unchanged, in_ready=0, FIFO level unchanged; release -> stream continues in order.
REQ-037 Stream 40 bytes through with wrap (pointers pass 15->0) -> output equals input XOR keystream byte-for-byte; byte_count=40 when RC4_XOR_BYTECOUNT_EN defined.
REQ-038 FAULT, then clear and rst asserted in separate runs -> both return to SYNC, level=0, ks_overflow=0, out_valid=0.
